// File: rtl/output_link_tx.sv
// Transmit end of a router-to-router link: registers crossbar flits onto the link and
// tracks each downstream VC through reserve, packet transfer and drain handshakes.
package noc_params;
   localparam int VC_NUM  = 2;
   localparam int VC_ID_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
   localparam int DATA_W  = 16;

   typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

   typedef struct packed {
      flit_label_t          flit_label;
      logic [VC_ID_W-1:0]   vc_id;
      logic [DATA_W-1:0]    data;
   } flit_t;
endpackage

module output_link_tx #(
   parameter int VC_NUM = noc_params::VC_NUM
) (
   input  logic                clk,
   input  logic                rst,
   input  noc_params::flit_t   flit_i,
   input  logic                valid_flit_i,
   input  logic [VC_NUM-1:0]   vc_grant_i,
   input  logic [VC_NUM-1:0]   on_off_i,
   input  logic [VC_NUM-1:0]   vc_allocatable_i,
   output noc_params::flit_t   data_o,
   output logic                valid_flit_o,
   output logic [VC_NUM-1:0]   vc_available_o,
   output logic [VC_NUM-1:0]   vc_ready_o,
   output logic [VC_NUM-1:0]   error_o
);
   import noc_params::*;

   typedef enum logic [2:0] {FREE, RESERVED, ACTIVE, DRAIN_LO, DRAIN_HI} vc_state_e;

   vc_state_e          state_q [VC_NUM];
   vc_state_e          state_d [VC_NUM];
   logic [VC_NUM-1:0]  error_q, error_d;
   flit_t              data_q, data_d;
   logic               valid_q, valid_d;

   logic               multi_grant;
   logic [VC_NUM-1:0]  flit_on, grant_err, flit_err, err_ev;

   // Protocol checks per VC; an offending event freezes that VC's state.
   always_comb begin
      multi_grant = ($countones(vc_grant_i) > 1);
      for (int v = 0; v < VC_NUM; v++) begin
         flit_on[v]   = valid_flit_i && (int'(flit_i.vc_id) == v);
         grant_err[v] = vc_grant_i[v] &&
                        (multi_grant || state_q[v] != FREE || !vc_allocatable_i[v]);
         flit_err[v]  = flit_on[v] &&
                        (!on_off_i[v] ||
                         state_q[v] inside {FREE, DRAIN_LO, DRAIN_HI} ||
                         (state_q[v] == RESERVED && flit_i.flit_label inside {BODY, TAIL}) ||
                         (state_q[v] == ACTIVE && flit_i.flit_label inside {HEAD, HEADTAIL}));
      end
      err_ev = grant_err | flit_err;
   end

   always_comb begin
      // NOTE: every _d signal takes its hold value first so no path leaves it unassigned (no latch).
      for (int v = 0; v < VC_NUM; v++) begin
         state_d[v] = state_q[v];
         if (!err_ev[v]) begin
            case (state_q[v])
               FREE:     if (vc_grant_i[v]) state_d[v] = RESERVED;
               RESERVED: if (flit_on[v])
                            state_d[v] = (flit_i.flit_label == HEADTAIL) ? DRAIN_LO : ACTIVE;
               ACTIVE:   if (flit_on[v] && flit_i.flit_label == TAIL) state_d[v] = DRAIN_LO;
               DRAIN_LO: if (!vc_allocatable_i[v]) state_d[v] = DRAIN_HI;
               DRAIN_HI: if (vc_allocatable_i[v]) state_d[v] = FREE;
               default:  state_d[v] = FREE;
            endcase
         end
      end
      error_d = error_q | err_ev;
      data_d  = flit_i;
      valid_d = valid_flit_i;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < VC_NUM; v++) state_q[v] <= FREE;
         error_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         for (int v = 0; v < VC_NUM; v++) state_q[v] <= state_d[v];
         error_q <= error_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      for (int v = 0; v < VC_NUM; v++) begin
         vc_available_o[v] = (state_q[v] == FREE) && vc_allocatable_i[v];
         vc_ready_o[v]     = (state_q[v] == RESERVED || state_q[v] == ACTIVE) && on_off_i[v];
      end
   end

   assign data_o       = data_q;
   assign valid_flit_o = valid_q;
   assign error_o      = error_q;
endmodule

// File: tb/tb_output_link_tx.sv
// Self-checking bench for output_link_tx: directed table, hand sequences and random
// traffic compared against a packet-level model of each downstream VC.
module tb_output_link_tx;
   import noc_params::*;
   localparam int N = VC_NUM;

   logic          clk = 1'b0;
   logic          rst;
   flit_t         flit_i;
   logic          valid_flit_i;
   logic [N-1:0]  vc_grant_i, on_off_i, vc_allocatable_i;
   flit_t         data_o;
   logic          valid_flit_o;
   logic [N-1:0]  vc_available_o, vc_ready_o, error_o;

   output_link_tx #(.VC_NUM(N)) dut (
      .clk              (clk),
      .rst              (rst),
      .flit_i           (flit_i),
      .valid_flit_i     (valid_flit_i),
      .vc_grant_i       (vc_grant_i),
      .on_off_i         (on_off_i),
      .vc_allocatable_i (vc_allocatable_i),
      .data_o           (data_o),
      .valid_flit_o     (valid_flit_o),
      .vc_available_o   (vc_available_o),
      .vc_ready_o       (vc_ready_o),
      .error_o          (error_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Packet-level model: a VC is owned after a grant, in a packet after a multi-flit head,
   // and drain counts the two allocatable-level phases after the tail.
   bit            m_owned  [N];
   bit            m_in_pkt [N];
   int            m_drain  [N];
   logic [N-1:0]  m_err;
   flit_t         m_data;
   logic          m_valid;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_free(int v);
      return !m_owned[v] && !m_in_pkt[v] && m_drain[v] == 0;
   endfunction

   task automatic model_reset();
      for (int v = 0; v < N; v++) begin
         m_owned[v] = 0; m_in_pkt[v] = 0; m_drain[v] = 0;
      end
      m_err = '0; m_data = '0; m_valid = 1'b0;
   endtask

   // One clock: combinational outputs checked before the edge, registered ones after it.
   task automatic cycle(input string tag);
      logic [N-1:0] ea, er;
      bit           multi, fl, bad;
      @(negedge clk);
      if (!rst) begin
         for (int v = 0; v < N; v++) begin
            ea[v] = m_free(v) && vc_allocatable_i[v];
            er[v] = (m_owned[v] || m_in_pkt[v]) && on_off_i[v];
         end
         check({tag, " vc_available"}, 64'(vc_available_o), 64'(ea));
         check({tag, " vc_ready"}, 64'(vc_ready_o), 64'(er));
      end
      if (rst) model_reset();
      else begin
         multi = $countones(vc_grant_i) > 1;
         for (int v = 0; v < N; v++) begin
            fl  = valid_flit_i && int'(flit_i.vc_id) == v;
            bad = vc_grant_i[v] && (multi || !m_free(v) || !vc_allocatable_i[v]);
            if (fl) begin
               if (!on_off_i[v] || !(m_owned[v] || m_in_pkt[v])) bad = 1;
               if (m_owned[v] && flit_i.flit_label inside {BODY, TAIL}) bad = 1;
               if (m_in_pkt[v] && flit_i.flit_label inside {HEAD, HEADTAIL}) bad = 1;
            end
            if (bad) m_err[v] = 1'b1;
            else if (m_free(v) && vc_grant_i[v]) m_owned[v] = 1;
            else if (m_owned[v] && fl) begin
               m_owned[v] = 0;
               if (flit_i.flit_label == HEAD) m_in_pkt[v] = 1;
               else m_drain[v] = 1;
            end else if (m_in_pkt[v] && fl && flit_i.flit_label == TAIL) begin
               m_in_pkt[v] = 0; m_drain[v] = 1;
            end else if (m_drain[v] == 1 && !vc_allocatable_i[v]) m_drain[v] = 2;
            else if (m_drain[v] == 2 && vc_allocatable_i[v]) m_drain[v] = 0;
         end
         m_data  = flit_i;
         m_valid = valid_flit_i;
      end
      @(posedge clk);
      #1;
      check({tag, " valid_flit_o"}, 64'(valid_flit_o), 64'(m_valid));
      check({tag, " data_o"}, 64'(data_o), 64'(m_data));
      check({tag, " error_o"}, 64'(error_o), 64'(m_err));
   endtask

   task automatic idle();
      vc_grant_i = '0; valid_flit_i = 1'b0; flit_i = '0;
   endtask

   task automatic send(input int vc, input flit_label_t lbl);
      valid_flit_i      = 1'b1;
      flit_i.vc_id      = VC_ID_W'(vc);
      flit_i.flit_label = lbl;
      flit_i.data       = DATA_W'($urandom);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; idle();
      for (int i = 0; i < n; i++) cycle("reset");
      rst = 1'b0;
   endtask

   function automatic flit_label_t legal_label(int vc);
      if (m_owned[vc]) return ($urandom_range(0, 1) != 0) ? HEAD : HEADTAIL;
      if (m_in_pkt[vc]) return ($urandom_range(0, 2) != 0) ? BODY : TAIL;
      return flit_label_t'($urandom_range(0, 3));
   endfunction

   typedef struct {
      logic [N-1:0] grant;
      logic         valid;
      flit_label_t  label;
      int           vc;
      logic [N-1:0] alloc;
      logic [N-1:0] exp_avail;
      logic [N-1:0] exp_ready;
      logic [N-1:0] exp_err;
   } vec_t;

   initial begin
      vec_t  tbl [8];
      flit_t sent;

      // Reset and idle state.
      on_off_i = '0; vc_allocatable_i = '0;
      do_reset(2);
      idle();
      vc_allocatable_i = 2'b10;
      #3;
      check("idle vc_available follows allocatable", 64'(vc_available_o), 64'(2'b10));
      check("idle vc_ready", 64'(vc_ready_o), 64'(0));
      cycle("idle");

      // HEAD/BODY/TAIL on VC1 then full drain handshake.
      tbl[0] = '{2'b10, 1'b0, HEAD,     0, 2'b11, 2'b11, 2'b00, 2'b00};
      tbl[1] = '{2'b00, 1'b1, HEAD,     1, 2'b11, 2'b01, 2'b10, 2'b00};
      tbl[2] = '{2'b00, 1'b1, BODY,     1, 2'b11, 2'b01, 2'b10, 2'b00};
      tbl[3] = '{2'b00, 1'b1, TAIL,     1, 2'b11, 2'b01, 2'b10, 2'b00};
      tbl[4] = '{2'b00, 1'b0, HEAD,     0, 2'b11, 2'b01, 2'b00, 2'b00};
      tbl[5] = '{2'b00, 1'b0, HEAD,     0, 2'b01, 2'b01, 2'b00, 2'b00};
      tbl[6] = '{2'b00, 1'b0, HEAD,     0, 2'b11, 2'b01, 2'b00, 2'b00};
      tbl[7] = '{2'b00, 1'b0, HEAD,     0, 2'b11, 2'b11, 2'b00, 2'b00};
      on_off_i = 2'b11;
      for (int i = 0; i < 8; i++) begin
         idle();
         vc_grant_i       = tbl[i].grant;
         vc_allocatable_i = tbl[i].alloc;
         if (tbl[i].valid) send(tbl[i].vc, tbl[i].label);
         #3;
         check($sformatf("tbl%0d vc_available", i), 64'(vc_available_o), 64'(tbl[i].exp_avail));
         check($sformatf("tbl%0d vc_ready", i), 64'(vc_ready_o), 64'(tbl[i].exp_ready));
         cycle($sformatf("tbl%0d", i));
         check($sformatf("tbl%0d error_o", i), 64'(error_o), 64'(tbl[i].exp_err));
      end

      // HEADTAIL on VC0 with a delayed allocatable low pulse.
      do_reset(1);
      idle(); vc_allocatable_i = 2'b11; vc_grant_i = 2'b01;
      cycle("ht grant");
      idle(); send(0, HEADTAIL);
      cycle("ht flit");
      idle();
      for (int i = 0; i < 3; i++) cycle("ht hold high");
      vc_allocatable_i[0] = 1'b0;
      cycle("ht low");
      vc_allocatable_i[0] = 1'b1;
      #3;
      check("ht rising edge cycle vc_available[0]", 64'(vc_available_o[0]), 64'(0));
      cycle("ht high");
      #3;
      check("ht released vc_available[0]", 64'(vc_available_o[0]), 64'(1));
      check("ht error_o", 64'(error_o), 64'(0));
      cycle("ht free");

      // BODY on a FREE VC: forwarded, flagged, VC stays FREE.
      idle(); send(0, BODY); sent = flit_i;
      cycle("body free");
      check("body free data_o", 64'(data_o), 64'(sent));
      check("body free error_o[0]", 64'(error_o[0]), 64'(1));
      idle();
      cycle("body free after");
      cycle("body free after2");
      check("body free sticky error_o[0]", 64'(error_o[0]), 64'(1));
      #3;
      check("body free vc_available[0]", 64'(vc_available_o[0]), 64'(1));

      // Flit while downstream is off: error, VC stays RESERVED.
      do_reset(1);
      idle(); on_off_i = 2'b01; vc_grant_i = 2'b10;
      cycle("off grant");
      idle(); send(1, HEAD);
      #3;
      check("off vc_ready[1]", 64'(vc_ready_o[1]), 64'(0));
      cycle("off head");
      check("off error_o[1]", 64'(error_o[1]), 64'(1));
      idle(); on_off_i = 2'b11;
      #3;
      check("off still reserved vc_ready[1]", 64'(vc_ready_o[1]), 64'(1));
      cycle("off on");

      // Multiple grants, then reset in the middle of a packet.
      do_reset(1);
      idle(); vc_grant_i = 2'b11;
      cycle("multi grant");
      check("multi grant error_o", 64'(error_o), 64'(2'b11));
      idle();
      #3;
      check("multi grant both free", 64'(vc_available_o), 64'(2'b11));
      cycle("multi after");
      do_reset(1);
      idle(); vc_grant_i = 2'b01;
      cycle("mid grant");
      idle(); send(0, HEAD);
      cycle("mid head");
      idle(); send(0, BODY); rst = 1'b1;
      cycle("mid reset");
      rst = 1'b0; idle();
      #3;
      check("mid reset vc_available[0]", 64'(vc_available_o[0]), 64'(1));
      check("mid reset vc_ready", 64'(vc_ready_o), 64'(0));
      check("mid reset error_o", 64'(error_o), 64'(0));
      cycle("mid after");

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         int r;
         int vc;
         idle();
         rst = ($urandom_range(0, 59) == 0);
         r = $urandom_range(0, 9);
         if (r == 0) vc_grant_i = N'($urandom);
         else if (r < 4) vc_grant_i = N'(1) << $urandom_range(0, N - 1);
         for (int v = 0; v < N; v++) begin
            if ($urandom_range(0, 3) == 0) vc_allocatable_i[v] = ~vc_allocatable_i[v];
            on_off_i[v] = ($urandom_range(0, 99) < 85);
         end
         if ($urandom_range(0, 9) < 6) begin
            vc = $urandom_range(0, N - 1);
            send(vc, ($urandom_range(0, 4) != 0) ? legal_label(vc)
                                                 : flit_label_t'($urandom_range(0, 3)));
         end
         cycle("random");
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/output_link_tx.md
Name: output_link_tx

Overview:
- Transmit end of one router-to-router link, one instance per output port, sitting downstream of the crossbar.
- Registers crossbar flits onto the link and tracks the state of every downstream VC from the downstream router's on_off and vc_allocatable feedback.
- Reports to the VC allocator which downstream VCs are free, and to the switch allocator which VCs may accept a flit this cycle.
- Flags protocol violations per VC.

Parameters:
- VC_NUM, noc_params VC_NUM: number of virtual channels per link.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- flit_i  in  flit_t  flit from crossbar (fields flit_label, vc_id used here)
- valid_flit_i  in  1  flit_i valid this cycle
- vc_grant_i  in  VC_NUM  VC allocator reservation of downstream VC, at most one bit set
- on_off_i  in  VC_NUM  downstream buffer flow control per VC (1 = may send)
- vc_allocatable_i  in  VC_NUM  downstream VC idle per VC
- data_o  out  flit_t  flit onto link
- valid_flit_o  out  1  data_o valid
- vc_available_o  out  VC_NUM  downstream VC free for allocation
- vc_ready_o  out  VC_NUM  switch allocator may send a flit on VC this cycle
- error_o  out  VC_NUM  sticky protocol error per VC

Behaviour:
- All state is updated on the rising clk edge. rst is synchronous and active-high.
- On rst:
  - every VC goes to FREE;
  - valid_flit_o=0, data_o=0, error_o=0;
  - rst mid-packet discards all in-flight state with no error.
- Datapath:
  - data_o and valid_flit_o are flit_i and valid_flit_i registered.
  - Latency is exactly 1 cycle.
  - No buffering and no stall: every valid input flit is forwarded, including erroneous ones.
- Per-VC FSM, v = 0..VC_NUM-1. A "flit on v" means valid_flit_i && flit_i.vc_id==v.
  - FREE: vc_grant_i[v] -> RESERVED.
  - RESERVED:
    - HEAD on v -> ACTIVE;
    - HEADTAIL on v -> DRAIN_LO.
  - ACTIVE:
    - BODY on v -> stay;
    - TAIL on v -> DRAIN_LO.
  - DRAIN_LO: vc_allocatable_i[v]==0 -> DRAIN_HI. This waits for the downstream VC to register the head.
  - DRAIN_HI: vc_allocatable_i[v]==1 -> FREE. This waits for the downstream VC to release the tail.
- Combinational outputs:
  - vc_available_o[v] = (state==FREE) & vc_allocatable_i[v].
  - vc_ready_o[v] = (state==RESERVED | state==ACTIVE) & on_off_i[v].
- Errors: error_o[v] is set, and stays 1 until rst, on any of:
  - vc_grant_i[v] while state != FREE or vc_allocatable_i[v]==0;
  - a flit on v while on_off_i[v]==0;
  - a flit on v while state is FREE, DRAIN_LO or DRAIN_HI;
  - BODY or TAIL on v in RESERVED;
  - HEAD or HEADTAIL on v in ACTIVE;
  - more than one vc_grant_i bit set. In this case error is set on all granted VCs and all grants are ignored.
- On an error event the FSM holds its current state, except that a grant error in FREE does not reserve.
- Simultaneous events:
  - a grant on v and a flit on another VC in the same cycle are both processed;
  - a grant on v and a flit on v in the same cycle (state FREE) set the error; the flit is not consumed as the head.
- DRAIN_LO is always entered for at least 1 cycle, so a VC is never re-offered on the stale allocatable level from before its head arrived.

Test Plan:
- rst held 2 cycles, then released with all inputs 0 -> valid_flit_o=0, error_o=0; vc_available_o = vc_allocatable_i; vc_ready_o=0.
- Grant VC1, send HEAD/BODY/TAIL on VC1 with on_off_i=all 1 -> data_o mirrors each flit 1 cycle later; vc_ready_o[1]=1 until the cycle the TAIL is presented; vc_available_o[1]=0 from the grant until vc_allocatable_i[1] drops to 0 and then returns to 1.
- Grant VC0, send HEADTAIL, keep vc_allocatable_i[0]=1 for 3 cycles, then 0, then 1 -> vc_available_o[0] stays 0 until the cycle after the 0->1 edge is sampled; error_o=0.
- Send BODY on VC0 while FREE -> flit still appears on data_o after 1 cycle; error_o[0]=1 and stays 1; VC0 remains FREE.
- Grant VC1 with on_off_i[1]=0, then send HEAD on VC1 -> vc_ready_o[1]=0 and error_o[1]=1; FSM stays RESERVED.
- vc_grant_i=2'b11 -> error_o=2'b11; both VCs remain FREE; assert rst mid-packet on VC0 -> next cycle VC0 is FREE and error_o=0.
